// File: rtl/circular_fifo.sv
// Circular-buffer FIFO with first-word fall-through head, count-decoded status flags
// and sticky overflow/underflow error flags.
module circular_fifo #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 1,
    parameter int unsigned AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [WIDTH-1:0]           d_in,
    input  logic                       se,
    output logic [WIDTH-1:0]           d_out,
    input  logic                       flush,
    input  logic                       clr_err,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf_set;
    logic             w_unf_set;

    // Status decode from the registered count
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == CW'(0));

    // A push into a full FIFO is legal when a pop frees the slot in the same cycle
    assign w_push    = !flush && we && (!w_full || se);
    assign w_pop     = !flush && se && !w_empty;
    assign w_ovf_set = !flush && we && w_full && !se;
    assign w_unf_set = !flush && se && w_empty;

    // Pointers, occupancy and sticky error flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
            r_overflow  <= w_ovf_set || (r_overflow  && !clr_err);
            r_underflow <= w_unf_set || (r_underflow && !clr_err);
        end
    end

    // Storage is deliberately not reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= d_in;
        end
    end

    assign d_out        = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (32'(r_count) >= AF_LEVEL);
    assign almost_empty = (32'(r_count) <= AE_LEVEL);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: doc/circular_fifo.md
CIRCULAR_FIFO -- requirements
Module: circular_fifo

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, number of storage entries; power of two, >=2.
REQ-003 Parameter AF_LEVEL, default DEPTH-1, almost_full asserts when count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 1, almost_empty asserts when count <= AE_LEVEL.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 we  input  1  push request; writes d_in when accepted.
REQ-008 d_in  input  WIDTH  push data.
REQ-009 se  input  1  pop request; removes the head entry when accepted.
REQ-010 d_out  output  WIDTH  head entry (first-word fall-through).
REQ-011 flush  input  1  synchronous discard of all entries.
REQ-012 clr_err  input  1  clears the sticky error flags.
REQ-013 count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-014 full, empty, almost_full, almost_empty  output  1 each  status flags, decoded from count.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Storage is a DEPTH-entry circular buffer addressed by read and write pointers of $clog2(DEPTH) bits, with wrap from DEPTH-1 to 0; no data shifting.
REQ-017 full = (count == DEPTH); empty = (count == 0); all flags are combinational from registered count.
REQ-018 d_out = entry at read pointer when !empty; d_out = 0 when empty.
REQ-019 Push accepted when we=1 and (!full or se=1); entry written at write pointer, write pointer advances one.
REQ-020 Pop accepted when se=1 and !empty; read pointer advances one; popped data was visible on d_out during the accepting cycle.
REQ-021 Write latency: pushed word visible on d_out the cycle after the push when the FIFO was empty.
REQ-022 Both accepted in one cycle: count unchanged; valid at full (pop frees the slot) and at any mid level.
REQ-023 we=1, se=0, full: write dropped, pointers/count unchanged, overflow set next edge.
REQ-024 se=1, empty: pop ignored, underflow set next edge; if we=1 in the same cycle, the push is still accepted (count 0->1).
REQ-025 Otherwise count increments on push-only and decrements on pop-only; no wrap of count beyond 0..DEPTH.
REQ-026 flush=1 has priority over we/se: both pointers and count go to 0 next edge; we/se that cycle are ignored and raise no error flags.
REQ-027 overflow/underflow remain set until clr_err=1 or reset; if clr_err and a new error coincide, the flag is set (set wins).
REQ-028 Storage contents are not cleared by flush or reset; only pointers and count.

Reset
REQ-029 rst=0 immediately (without clk) forces pointers, count, overflow, underflow to 0; hence empty=1, full=0, d_out=0, almost_empty=1, almost_full=0 (AF_LEVEL>0).
REQ-030 Reset asserted mid-operation discards all contents; the first push after rst rises behaves as into an empty FIFO.
REQ-031 rst deassertion is synchronised externally; the block accepts we/se on the first rising edge with rst=1.

Verification (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-032 Push 0x11,0x22,0x33,0x44 then pop x4 -> d_out 0x11,0x22,0x33,0x44 in order; count 1,2,3,4 then 3,2,1,0; almost_full at count 3, full at 4, empty at end.
REQ-033 Fill to 4, push 0x55 with se=0 -> count stays 4, overflow=1, head still 0x11; clr_err pulse -> overflow=0.
REQ-034 Full, we=1 se=1 d_in=0x66 -> count stays 4, d_out becomes 0x22; pop 4 more -> 0x22,0x33,0x44,0x66 (pointer wrap).
REQ-035 Empty, se=1 we=1 d_in=0x77 -> underflow=1, count=1, d_out=0x77 next cycle.
REQ-036 Count 3, flush=1 with we=1 -> next edge count=0, empty=1, no error flags; then rst=0 mid-cycle -> flags clear asynchronously before next clk edge.
REQ-037 Random push/pop/flush for 10k cycles vs. queue model -> d_out, count, all flags match every cycle.
